// File: rtl/pdm_cic_decimator_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_cic_decimator_mc
//  Description : Multi-channel PDM to PCM CIC decimator. Per-channel
//                integrators run on every sample strobe. A single
//                time-shared comb section walks the channels after each
//                decimation boundary and presents one channel at a time on
//                a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_cic_decimator_mc #(
    parameter int ORDER    = 3,
    parameter int DEC_LOG2 = 6,
    parameter int CHANNELS = 2,
    parameter int OUT_W    = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        sample_en,
    input  logic [CHANNELS-1:0]                         sampled_bits,
    output logic signed [OUT_W-1:0]                     pcm_sample,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] pcm_channel,
    output logic                                        pcm_valid,
    input  logic                                        pcm_ready,
    output logic                                        overrun,
    input  logic                                        clr_overrun
);

    localparam int ACC_W   = ORDER * DEC_LOG2 + 2;
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SHIFT   = ORDER * DEC_LOG2 - (OUT_W - 1);
    localparam int SHIFT_R = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHIFT_L = (SHIFT < 0) ? -SHIFT : 0;
    // Wide enough that a left shift of the accumulator cannot lose bits
    // before the saturation compare.
    localparam int EXT_W   = ACC_W + OUT_W;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    localparam logic signed [ACC_W-1:0] PLUS_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] MINUS_ONE = {ACC_W{1'b1}};

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(ACC_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(ACC_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COMB = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic signed [ACC_W-1:0] integ     [CHANNELS][ORDER];
    logic signed [ACC_W-1:0] integ_nxt [CHANNELS][ORDER];
    logic signed [ACC_W-1:0] dly       [CHANNELS][ORDER];
    logic signed [ACC_W-1:0] snap      [CHANNELS];
    logic signed [ACC_W-1:0] comb_y    [ORDER+1];
    logic signed [EXT_W-1:0] y_ext;
    logic signed [EXT_W-1:0] y_scaled;
    logic signed [OUT_W-1:0] y_sat;
    logic [DEC_LOG2-1:0]     cnt;
    logic [CH_W-1:0]         ch;
    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic                    strobe;
    logic                    boundary;

    assign strobe   = en & sample_en;
    assign boundary = strobe & (&cnt);

    // Integrator cascade: each stage adds the freshly updated previous stage
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            integ_nxt[c][0] = integ[c][0] + (sampled_bits[c] ? PLUS_ONE : MINUS_ONE);
            for (int k = 1; k < ORDER; k++) begin
                integ_nxt[c][k] = integ[c][k] + integ_nxt[c][k-1];
            end
        end
    end

    // Integrator and decimation counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < ORDER; k++)
                    integ[c][k] <= '0;
        end else if (!en) begin
            cnt <= '0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < ORDER; k++)
                    integ[c][k] <= '0;
        end else if (sample_en) begin
            cnt <= cnt + 1'b1;
            integ <= integ_nxt;
        end
    end

    // Snapshot capture at a boundary; a boundary while busy is dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) snap[c] <= '0;
        end else begin
            if (boundary && state != S_IDLE)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            if (!en) begin
                for (int c = 0; c < CHANNELS; c++) snap[c] <= '0;
            end else if (boundary && state == S_IDLE) begin
                for (int c = 0; c < CHANNELS; c++) snap[c] <= integ_nxt[c][ORDER-1];
            end
        end
    end

    // Comb chain for the selected channel, then scale and saturate
    always_comb begin
        comb_y[0] = snap[ch];
        for (int k = 0; k < ORDER; k++) begin
            comb_y[k+1] = comb_y[k] - dly[ch][k];
        end
        y_ext    = {{OUT_W{comb_y[ORDER][ACC_W-1]}}, comb_y[ORDER]};
        y_scaled = (y_ext >>> SHIFT_R) <<< SHIFT_L;
        if (y_scaled > SAT_MAX)
            y_sat = SAT_MAX[OUT_W-1:0];
        else if (y_scaled < SAT_MIN)
            y_sat = SAT_MIN[OUT_W-1:0];
        else
            y_sat = y_scaled[OUT_W-1:0];
    end

    // Comb delays and output register, updated only for the channel in COMB
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            pcm_sample  <= '0;
            pcm_channel <= '0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < ORDER; k++)
                    dly[c][k] <= '0;
        end else if (state == S_COMB) begin
            pcm_sample  <= y_sat;
            pcm_channel <= ch;
            for (int k = 0; k < ORDER; k++)
                dly[ch][k] <= comb_y[k];
        end
    end

    // Channel index walks 0..CHANNELS-1 across one output frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
        end else if (!en) begin
            ch <= '0;
        end else if (state == S_IDLE && boundary) begin
            ch <= '0;
        end else if (state == S_OUT && pcm_ready && ch != LAST_CH) begin
            ch <= ch + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else if (!en)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (boundary) state_nxt = S_COMB;
            S_COMB:  state_nxt = S_OUT;
            S_OUT:   if (pcm_ready) state_nxt = (ch == LAST_CH) ? S_IDLE : S_COMB;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: valid is asserted for the whole OUT state
    always_comb begin
        pcm_valid = (state == S_OUT);
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_cic_decimator_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdm_cic_decimator_mc
//  Description : Self-checking bench for pdm_cic_decimator_mc. The golden
//                model is a direct cascade of length-R moving sums over the
//                +/-1 input history, scaled and saturated.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_cic_decimator_mc;

    localparam int ORDER    = 3;
    localparam int DEC_LOG2 = 6;
    localparam int CHANNELS = 2;
    localparam int OUT_W    = 16;
    localparam int R        = 1 << DEC_LOG2;
    localparam int S        = ORDER * DEC_LOG2 - (OUT_W - 1);
    localparam int SR       = (S > 0) ? S : 0;
    localparam int SL       = (S < 0) ? -S : 0;
    localparam int MAXS     = 1024;
    localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OUT_W - 1));

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       en = 1'b1;
    logic                       sample_en = 1'b0;
    logic [CHANNELS-1:0]        sampled_bits = '0;
    logic signed [OUT_W-1:0]    pcm_sample;
    logic [0:0]                 pcm_channel;
    logic                       pcm_valid;
    logic                       pcm_ready = 1'b1;
    logic                       overrun;
    logic                       clr_overrun = 1'b0;

    pdm_cic_decimator_mc #(
        .ORDER(ORDER), .DEC_LOG2(DEC_LOG2), .CHANNELS(CHANNELS), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sample_en(sample_en),
        .sampled_bits(sampled_bits), .pcm_sample(pcm_sample),
        .pcm_channel(pcm_channel), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint val;
    } exp_t;

    typedef struct {
        int     m0;
        int     m1;
        int     frames;
        longint exp0;
        longint exp1;
    } vec_t;

    exp_t   q[$];
    longint hist [CHANNELS][ORDER+1][MAXS];
    int     nsamp = 0;
    int     checks = 0;
    int     passes = 0;
    logic   sb_on = 1'b0;
    longint last_out [CHANNELS];
    int     n_out [CHANNELS];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint scale_sat(input longint v);
        longint r;
        r = (v >>> SR) <<< SL;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        return r;
    endfunction

    function automatic logic pat(input int mode, input int n);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (n % 2) == 0;
            3:       return (n % 4) == 0;
            default: return (n % 4) != 0;
        endcase
    endfunction

    task automatic model_reset();
        nsamp = 0;
        q.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            n_out[c]    = 0;
            last_out[c] = 0;
        end
    endtask

    task automatic model_step(input logic [CHANNELS-1:0] b);
        exp_t e;
        longint s;
        if (nsamp >= MAXS) begin
            $display("FAIL model_history: got %0d expected below %0d", nsamp, MAXS);
            $fatal(1, "model history exhausted");
        end
        for (int c = 0; c < CHANNELS; c++) begin
            hist[c][0][nsamp] = b[c] ? 64'sd1 : -64'sd1;
            for (int k = 1; k <= ORDER; k++) begin
                s = 0;
                for (int i = 0; i < R; i++)
                    if (nsamp - i >= 0) s += hist[c][k-1][nsamp-i];
                hist[c][k][nsamp] = s;
            end
        end
        if ((nsamp % R) == R - 1) begin
            for (int c = 0; c < CHANNELS; c++) begin
                e.ch  = c;
                e.val = scale_sat(hist[c][ORDER][nsamp]);
                q.push_back(e);
            end
        end
        nsamp++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_strobes(input int n, input int m0, input int m1);
        for (int i = 0; i < n; i++) begin
            sampled_bits[0] = pat(m0, nsamp);
            sampled_bits[1] = pat(m1, nsamp);
            sample_en = 1'b1;
            model_step(sampled_bits);
            tick();
            sample_en = 1'b0;
            tick();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Scoreboard: every completed handshake is compared against the queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_on && pcm_valid && pcm_ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: got ch %0d sample %0d expected no output",
                         pcm_channel, pcm_sample);
            end else begin
                e = q.pop_front();
                check("sb_channel", pcm_channel, e.ch);
                check("sb_sample", pcm_sample, e.val);
                last_out[pcm_channel] = pcm_sample;
                n_out[pcm_channel]++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        longint exp_first0;
        int     wait_cnt;

        tbl[0] = '{m0: 1, m1: 0, frames: 5, exp0: 32767,  exp1: -32768};
        tbl[1] = '{m0: 2, m1: 2, frames: 5, exp0: 0,      exp1: 0};
        tbl[2] = '{m0: 3, m1: 4, frames: 5, exp0: -16384, exp1: 16384};
        tbl[3] = '{m0: 4, m1: 1, frames: 5, exp0: 16384,  exp1: 32767};

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", pcm_valid, 0);
        check("rst_sample", pcm_sample, 0);
        check("rst_channel", pcm_channel, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Boundary-to-output latency
        pcm_ready = 1'b1;
        sb_on = 1'b1;
        run_strobes(R - 1, 1, 0);
        sampled_bits = 2'b01;
        sample_en = 1'b1;
        model_step(sampled_bits);
        @(negedge clk);
        check("lat_T0_valid", pcm_valid, 0);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        @(negedge clk);
        check("lat_T1_valid", pcm_valid, 0);
        @(negedge clk);
        check("lat_T2_valid", pcm_valid, 1);
        check("lat_T2_channel", pcm_channel, 0);
        @(negedge clk);
        check("lat_T3_valid", pcm_valid, 0);
        @(negedge clk);
        check("lat_T4_valid", pcm_valid, 1);
        check("lat_T4_channel", pcm_channel, 1);
        repeat (6) tick();
        check("lat_drain", q.size(), 0);

        // Steady-state vectors
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            pcm_ready = 1'b1;
            sb_on = 1'b1;
            run_strobes(tbl[r].frames * R, tbl[r].m0, tbl[r].m1);
            repeat (12) tick();
            check("vec_count0", n_out[0], tbl[r].frames);
            check("vec_count1", n_out[1], tbl[r].frames);
            check("vec_last0", last_out[0], tbl[r].exp0);
            check("vec_last1", last_out[1], tbl[r].exp1);
            check("vec_drain", q.size(), 0);
        end

        // Overrun with stalled consumer
        apply_reset();
        sb_on = 1'b0;
        pcm_ready = 1'b0;
        run_strobes(R, 1, 0);
        exp_first0 = q[0].val;
        @(negedge clk);
        check("ovr_valid", pcm_valid, 1);
        check("ovr_channel", pcm_channel, 0);
        check("ovr_sample_first", pcm_sample, exp_first0);
        check("ovr_pre", overrun, 0);
        run_strobes(R, 1, 0);
        @(negedge clk);
        check("ovr_set", overrun, 1);
        check("ovr_hold_valid", pcm_valid, 1);
        check("ovr_hold_channel", pcm_channel, 0);
        check("ovr_hold_sample", pcm_sample, exp_first0);
        @(posedge clk);
        #1;
        run_strobes(R - 1, 1, 0);
        sampled_bits = 2'b01;
        sample_en = 1'b1;
        clr_overrun = 1'b1;
        model_step(sampled_bits);
        tick();
        sample_en = 1'b0;
        clr_overrun = 1'b0;
        @(negedge clk);
        check("ovr_set_wins", overrun, 1);
        @(posedge clk);
        #1;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        @(posedge clk);
        #1;

        // Re-arm overrun, then drop en mid-frame
        run_strobes(R, 1, 0);
        @(negedge clk);
        check("en_pre_overrun", overrun, 1);
        @(posedge clk);
        #1;
        run_strobes(20, 1, 0);
        en = 1'b0;
        tick();
        en = 1'b1;
        model_reset();
        @(negedge clk);
        check("en_valid_dropped", pcm_valid, 0);
        check("en_overrun_kept", overrun, 1);
        @(posedge clk);
        #1;
        pcm_ready = 1'b1;
        sb_on = 1'b1;
        run_strobes(4 * R, 1, 0);
        repeat (12) tick();
        check("en_count0", n_out[0], 4);
        check("en_count1", n_out[1], 4);
        check("en_last0", last_out[0], 32767);
        check("en_last1", last_out[1], -32768);
        check("en_overrun_after", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // Asynchronous reset in the middle of a handshake
        apply_reset();
        sb_on = 1'b0;
        pcm_ready = 1'b0;
        run_strobes(R, 1, 0);
        wait_cnt = 0;
        @(negedge clk);
        while (!pcm_valid && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("arst_pre_valid", pcm_valid, 1);
        check("arst_pre_sample", pcm_sample, scale_sat(hist[0][ORDER][R-1]));
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", pcm_valid, 0);
        check("arst_sample", pcm_sample, 0);
        check("arst_channel", pcm_channel, 0);
        check("arst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        pcm_ready = 1'b1;
        sb_on = 1'b1;
        run_strobes(2 * R, 1, 0);
        repeat (12) tick();
        check("arst_count0", n_out[0], 2);
        check("arst_count1", n_out[1], 2);
        check("arst_drain", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
